// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock FIFO with standard or first-word-fall-through read
//
// Purpose: synchronous FIFO of 2^c_DEPTH_WIDTH words backed by an inferred
// RAM (one write port, one registered read port, no storage reset).
// c_FWFT=0 gives a standard read (data one cycle after rd_en); c_FWFT=1 keeps
// the head word on rd_data whenever rd_empty is low.
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset
//   wr_data      write data
//   wr_en        write request, accepted while wr_full is low
//   wr_full      FIFO holds capacity words
//   almost_full  water_level >= c_ALMOST_FULL_NUM
//   rd_data      read data (FWFT: current head word)
//   rd_en        read request (FWFT: acknowledge of head word)
//   rd_empty     no readable word
//   almost_empty water_level <= c_ALMOST_EMPTY_NUM
//   water_level  number of words stored
//   flag_clr     clears the sticky error flags
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty

module sync_fifo_fwft #(
   parameter int c_DEPTH_WIDTH      = 10,
   parameter int c_DATA_WIDTH       = 32,
   parameter int c_FWFT             = 0,
   parameter int c_ALMOST_FULL_NUM  = 1020,
   parameter int c_ALMOST_EMPTY_NUM = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [c_DATA_WIDTH-1:0]  wr_data,
   input  logic                     wr_en,
   output logic                     wr_full,
   output logic                     almost_full,
   output logic [c_DATA_WIDTH-1:0]  rd_data,
   input  logic                     rd_en,
   output logic                     rd_empty,
   output logic                     almost_empty,
   output logic [c_DEPTH_WIDTH:0]   water_level,
   input  logic                     flag_clr,
   output logic                     overflow,
   output logic                     underflow
);

   localparam logic [c_DEPTH_WIDTH:0]   c_CAP     = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
   localparam logic [c_DEPTH_WIDTH:0]   c_LVL_ONE = {{c_DEPTH_WIDTH{1'b0}}, 1'b1};
   localparam logic [c_DEPTH_WIDTH-1:0] c_PTR_ONE = {{(c_DEPTH_WIDTH-1){1'b0}}, 1'b1};

   logic [c_DATA_WIDTH-1:0]  r_mem [0:(1<<c_DEPTH_WIDTH)-1];
   logic [c_DEPTH_WIDTH-1:0] r_wr_ptr;
   logic [c_DEPTH_WIDTH-1:0] r_rd_ptr;
   logic [c_DEPTH_WIDTH:0]   r_level;
   logic [c_DATA_WIDTH-1:0]  r_rd_data;
   logic                     r_overflow;
   logic                     r_underflow;

   logic                     w_wr_acc;
   logic                     w_rd_acc;
   logic                     w_empty;
   logic [c_DEPTH_WIDTH-1:0] w_rd_ptr_nxt;
   logic [31:0]              w_level32;

   assign w_wr_acc     = wr_en & ~wr_full;
   assign w_rd_acc     = rd_en & ~w_empty;
   assign w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;
   assign w_level32    = {{(31-c_DEPTH_WIDTH){1'b0}}, r_level};

   assign wr_full      = (r_level == c_CAP);
   assign almost_full  = (w_level32 >= 32'(c_ALMOST_FULL_NUM));
   assign almost_empty = (w_level32 <= 32'(c_ALMOST_EMPTY_NUM));
   assign water_level  = r_level;
   assign rd_empty     = w_empty;
   assign rd_data      = r_rd_data;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + c_LVL_ONE;
            2'b01:   r_level <= r_level - c_LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // A new error in the same cycle as flag_clr wins, so the flag stays set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && wr_full) begin
            r_overflow <= 1'b1;
         end else if (flag_clr) begin
            r_overflow <= 1'b0;
         end
         if (rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end else if (flag_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   generate
      if (c_FWFT != 0) begin : g_fwft
         // Storage keeps every word until it is acknowledged, so the output
         // register is only a copy of the head slot and capacity is unchanged.
         logic r_valid;
         logic w_load_mem;
         logic w_bypass;

         // A word that was already in RAM before this edge remains after the read.
         assign w_load_mem = (r_level > {{c_DEPTH_WIDTH{1'b0}}, w_rd_acc});
         // Level 1 with read+write: the new word becomes head; take it straight
         // from wr_data because the RAM write lands on this same edge.
         assign w_bypass   = w_rd_acc & w_wr_acc & ~w_load_mem;
         assign w_empty    = ~r_valid;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid   <= 1'b0;
               r_rd_data <= '0;
            end else if (w_load_mem) begin
               r_valid   <= 1'b1;
               r_rd_data <= r_mem[w_rd_ptr_nxt];
            end else if (w_bypass) begin
               r_valid   <= 1'b1;
               r_rd_data <= wr_data;
            end else begin
               r_valid   <= 1'b0;
            end
         end
      end else begin : g_std
         assign w_empty = (r_level == '0);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_rd_data <= '0;
            end else if (w_rd_acc) begin
               r_rd_data <= r_mem[r_rd_ptr];
            end
         end
      end
   endgenerate

endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 SHALL have parameter c_DEPTH_WIDTH, default 10, meaning log2 capacity; legal 2..12; capacity 2^c_DEPTH_WIDTH words.
REQ-002 SHALL have parameter c_DATA_WIDTH, default 32, meaning word width; legal 1..256.
REQ-003 SHALL have parameter c_FWFT, default 0, meaning 0 = standard read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter c_ALMOST_FULL_NUM, default 1020, meaning almost_full threshold in words.
REQ-005 SHALL have parameter c_ALMOST_EMPTY_NUM, default 4, meaning almost_empty threshold in words.
REQ-006 Port list, in order, SHALL be:
- clk  input  1  sole clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- wr_data  input  c_DATA_WIDTH  write data.
- wr_en  input  1  write request.
- wr_full  output  1  FIFO holds capacity words.
- almost_full  output  1  level at/above threshold.
- rd_data  output  c_DATA_WIDTH  read data.
- rd_en  input  1  read request (FWFT: acknowledge of head word).
- rd_empty  output  1  no readable word.
- almost_empty  output  1  level at/below threshold.
- water_level  output  c_DEPTH_WIDTH+1  words stored.
- flag_clr  input  1  clears sticky error flags.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Function
REQ-007 Write SHALL be accepted iff wr_en=1 and wr_full=0, regardless of rd_en in same cycle.
REQ-008 Read SHALL be accepted iff rd_en=1 and rd_empty=0, regardless of wr_en in same cycle.
REQ-009 Words SHALL leave in write order; write and read pointers SHALL wrap modulo 2^c_DEPTH_WIDTH with no gap or duplicate.
REQ-010 water_level SHALL be registered: +1 next cycle for accepted write only, -1 for accepted read only, unchanged for both or neither; range 0..2^c_DEPTH_WIDTH.
REQ-011 wr_full SHALL equal (water_level == 2^c_DEPTH_WIDTH); capacity SHALL be exactly 2^c_DEPTH_WIDTH words in both modes.
REQ-012 almost_full SHALL equal (water_level >= c_ALMOST_FULL_NUM); almost_empty SHALL equal (water_level <= c_ALMOST_EMPTY_NUM); both combinational from water_level, no extra latency.
REQ-013 Standard mode (c_FWFT=0): rd_empty SHALL equal (water_level==0); accepted read in cycle N SHALL present the head word on rd_data in cycle N+1; rd_data SHALL hold its value when no read is accepted.
REQ-014 Standard mode: write accepted in cycle N to empty FIFO SHALL deassert rd_empty in cycle N+1, word readable with rd_en in N+1.
REQ-015 FWFT mode (c_FWFT=1): whenever rd_empty=0, rd_data SHALL already carry the head word; accepted read in cycle N SHALL present the next word (or assert rd_empty) in cycle N+1.
REQ-016 FWFT mode: write accepted in cycle N to empty FIFO SHALL deassert rd_empty in cycle N+2 with that word on rd_data; water_level rises in N+1.
REQ-017 FWFT mode: back-to-back accepted reads SHALL sustain one word per cycle while water_level >= 2; no bubble on simultaneous read and write at water_level 1.
REQ-018 Write while wr_full=1 SHALL be dropped and set overflow next cycle; read while rd_empty=1 SHALL be ignored and set underflow next cycle; FIFO state unchanged.
REQ-019 Simultaneous write+read on empty FIFO: write accepted, read rejected, underflow set. On full FIFO: read accepted, write rejected, overflow set.
REQ-020 flag_clr=1 SHALL clear overflow and underflow next cycle; a same-cycle new error SHALL take priority and keep its flag set.
REQ-021 Memory SHALL be an inferred array of 2^c_DEPTH_WIDTH x c_DATA_WIDTH with one write port and one registered read port; no reset on storage.

Reset
REQ-022 rst=1 at a clock edge SHALL set pointers and water_level to 0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0 (unless c_ALMOST_FULL_NUM=0), rd_data=0, overflow=0, underflow=0.
REQ-023 rst SHALL override wr_en, rd_en and flag_clr in the same cycle; reset mid-operation SHALL discard all stored words.
REQ-024 First write SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-025 Depth 4, width 8, standard: write 0x11,0x22,0x33,0x44 -> wr_full=1, water_level=4; write 0x55 -> overflow=1, level 4; read 4 -> 0x11..0x44 each one cycle after rd_en, rd_empty=1.
REQ-026 FWFT, empty: write 0xA5 at cycle N -> water_level=1 at N+1, rd_empty=0 and rd_data=0xA5 at N+2; rd_en at N+2 -> rd_empty=1 at N+3.
REQ-027 Depth 4, continuous simultaneous write/read for 20 cycles after prefill of 2 -> water_level stays 2, data order matches writes across 5 pointer wraps, no flags.
REQ-028 Empty FIFO, wr_en=rd_en=1 same cycle -> level 1, underflow=1; flag_clr -> underflow=0 next cycle.
REQ-029 Thresholds AF=3, AE=1, depth 4: fill 0..4 words -> almost_empty 1,1,0,0,0; almost_full 0,0,0,1,1.
REQ-030 Fill 3 words, assert rst one cycle -> all outputs at REQ-022 values next cycle; subsequent write/read returns only new data.
